// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared channel state encoding and default sizing for the
// ADC-side capture controller (adc_div2_clk domain).
package adc_capture_pkg;

  // Default sizing: 8 channels, 8 samples x 16 bits per div2 clock,
  // 2048-word capture buffers per channel.
  localparam int DEF_NCHAN       = 8;
  localparam int DEF_SAMPLE_BITS = 128;
  localparam int DEF_ADDR_BITS   = 11;
  localparam int DEF_DEPTH       = 2048;

  // Width of the optional holdoff delay, counted in adc_div2_clk cycles.
  localparam int HOLDOFF_BITS    = 16;

  // Per-channel sequencing states. HOLDOFF is only reachable in the
  // holdoff-enabled build; the encoding stays fixed so both builds agree.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLDOFF = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } chan_state_e;

endpackage

// File: rtl/adc_capture_chan.sv
// adc_capture_chan: one channel of the capture controller. It holds the
// channel FSM, the write address counter and the registered BRAM write port.
// Optional pre-capture delay is compiled in with ADC_CAPTURE_CTRL_HOLDOFF_EN.
module adc_capture_chan
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_capture,
  input  logic                    i_chanEn,
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
  input  logic [HOLDOFF_BITS-1:0] i_holdoff,
`endif
  input  logic                    i_valid,
  input  logic [SAMPLE_BITS-1:0]  i_data,
  output logic                    o_we,
  output logic [ADDR_BITS-1:0]    o_addr,
  output logic [SAMPLE_BITS-1:0]  o_data,
  output logic                    o_done,
  output logic                    o_busy
);

  // One extra counter bit so the counter can reach DEPTH itself, which
  // marks "all words written" even when DEPTH == 2^ADDR_BITS.
  localparam int                  CNT_BITS = ADDR_BITS + 1;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(DEPTH);

  chan_state_e           r_state;
  logic [CNT_BITS-1:0]   r_cnt;
  logic                  r_done;
  logic                  r_busy;
  logic                  r_we;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [SAMPLE_BITS-1:0] r_data;
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
  logic [HOLDOFF_BITS-1:0] r_hold;
`endif

  logic w_write;

  // A sample is accepted only while capturing and only until DEPTH words
  // have been taken, so the address never wraps inside one capture.
  assign w_write = (r_state == ST_CAPTURE) && i_valid && (r_cnt != LAST_CNT);

  // Channel sequencing: arm on a qualified capture, optionally wait out the
  // holdoff, take DEPTH valid words, then park in DONE with done raised.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
      r_hold  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_capture) begin
            r_cnt <= '0;
            if (i_chanEn) begin
              r_done <= 1'b0;
              r_busy <= 1'b1;
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
              if (i_holdoff == '0) begin
                r_state <= ST_CAPTURE;
              end else begin
                r_state <= ST_HOLDOFF;
                r_hold  <= i_holdoff;
              end
`else
              r_state <= ST_CAPTURE;
`endif
            end else begin
              // Masked channels report done at once so the PS can poll
              // the whole done vector regardless of the enable mask.
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
        ST_HOLDOFF: begin
          if (r_hold == HOLDOFF_BITS'(1)) begin
            r_state <= ST_CAPTURE;
          end
          r_hold <= r_hold - HOLDOFF_BITS'(1);
        end
`endif
        ST_CAPTURE: begin
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_write) begin
            r_cnt <= r_cnt + CNT_BITS'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Registered write port: strobe, address and data all appear one cycle
  // after the accepted sample so they stay aligned at the BRAM.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr <= r_cnt[ADDR_BITS-1:0];
        r_data <= i_data;
      end
    end
  end

  assign o_we   = r_we;
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_done = r_done;
  assign o_busy = r_busy;

endmodule

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: ADC-side end of the PS capture/done handshake. Takes the
// synchronised capture pulse, fans it out to NCHAN channel engines that fill
// the capture BRAMs, and reports per-channel done plus an overall busy.
// Optional holdoff delay (holdoff_i port) is enabled by defining
// ADC_CAPTURE_CTRL_HOLDOFF_EN.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int NCHAN       = DEF_NCHAN,
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int ADDR_BITS   = DEF_ADDR_BITS,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                         adc_div2_clk,
  input  logic                         rst,
  input  logic                         capture_i,
  input  logic [NCHAN-1:0]             chan_en_i,
  input  logic [NCHAN-1:0]             adc_valid_i,
  input  logic [NCHAN*SAMPLE_BITS-1:0] adc_data_i,
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
  input  logic [HOLDOFF_BITS-1:0]      holdoff_i,
`endif
  output logic [NCHAN-1:0]             bram_we_o,
  output logic [NCHAN*ADDR_BITS-1:0]   bram_addr_o,
  output logic [NCHAN*SAMPLE_BITS-1:0] bram_data_o,
  output logic [NCHAN-1:0]             done_o,
  output logic                         busy_o
);

  logic [NCHAN-1:0] w_chanBusy;
  logic             w_anyBusy;
  logic             w_captureQual;

  // While any channel is still holding off or capturing, a new request is
  // dropped for every channel so all buffers always belong to one trigger.
  assign w_anyBusy     = |w_chanBusy;
  assign w_captureQual = capture_i & ~w_anyBusy;
  assign busy_o        = w_anyBusy;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    adc_capture_chan #(
      .SAMPLE_BITS (SAMPLE_BITS),
      .ADDR_BITS   (ADDR_BITS),
      .DEPTH       (DEPTH)
    ) u_chan (
      .i_clk     (adc_div2_clk),
      .i_rst     (rst),
      .i_capture (w_captureQual),
      .i_chanEn  (chan_en_i[c]),
`ifdef ADC_CAPTURE_CTRL_HOLDOFF_EN
      .i_holdoff (holdoff_i),
`endif
      .i_valid   (adc_valid_i[c]),
      .i_data    (adc_data_i[c*SAMPLE_BITS +: SAMPLE_BITS]),
      .o_we      (bram_we_o[c]),
      .o_addr    (bram_addr_o[c*ADDR_BITS +: ADDR_BITS]),
      .o_data    (bram_data_o[c*SAMPLE_BITS +: SAMPLE_BITS]),
      .o_done    (done_o[c]),
      .o_busy    (w_chanBusy[c])
    );
  end

endmodule
